axi_dma_wr: RTL

AXI4 DMA write master. It accepts a command (base address, byte count, tag) and pulls a beat stream from an internal producer with backpressure. It splits the transfer into legal INCR bursts (MAX_BURST_LEN cap, no 4 KB crossing) and issues AW, W and B per burst, with one burst outstanding at a time. It is the write-direction peer of the DMA read master and sits between the NPU writeback path and the AXI interconnect.

---
 rtl/axi_types_pkg.sv | 27 ++
 rtl/axi_burst_calc.sv | 31 +++
 rtl/axi_dma_wr.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/axi_types_pkg.sv
// Shared AXI4 types and helpers for the DMA masters.
// Latency: n/a (constants and pure functions only).
// Backpressure: n/a.
package axi_types_pkg;

    localparam int AXI_ID_W = 4;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
    localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
    localparam logic [1:0] AXI_BURST_WRAP  = 2'b10;

    // AxSIZE encoding for a power-of-two beat width in bytes (1..128).
    function automatic logic [2:0] axi_size_from_bytes(input int unsigned bytes);
        logic [2:0] sz;
        sz = '0;
        for (int i = 0; i < 8; i++) begin
            if (bytes == (32'd1 << i)) sz = 3'(i);
        end
        return sz;
    endfunction

endpackage

// File: rtl/axi_burst_calc.sv
// Burst sizer: beats = min(MAX_BURST_LEN, ceil(rem/BPB), beats to next 4 KB boundary), output as beats-1.
// Latency: purely combinational.
// Backpressure: none; caller must not use the result when rem == 0.
module axi_burst_calc #(
    parameter int BEAT_SHIFT    = 4,
    parameter int MAX_BURST_LEN = 16
) (
    input  logic [11:0] addr_4k,
    input  logic [23:0] rem,
    output logic [7:0]  burst_len
);

    localparam int RB_W = 25 - BEAT_SHIFT;

    logic [RB_W-1:0] rem_beats;
    logic [12:0]     bytes_to_4k;
    logic [12:0]     beats_to_4k;
    logic [8:0]      beats;

    // Remaining beats rounded up; distance to the 4 KB page end in beats (address is beat aligned).
    always_comb begin
        rem_beats   = {1'b0, rem[23:BEAT_SHIFT]} + RB_W'(|rem[BEAT_SHIFT-1:0]);
        bytes_to_4k = 13'd4096 - {1'b0, addr_4k};
        beats_to_4k = bytes_to_4k >> BEAT_SHIFT;
        beats       = 9'(MAX_BURST_LEN);
        if (beats_to_4k < {4'b0, beats}) beats = beats_to_4k[8:0];
        if (rem_beats < RB_W'(beats))    beats = rem_beats[8:0];
        burst_len   = 8'(beats - 9'd1);
    end

endmodule

// File: rtl/axi_dma_wr.sv
// AXI4 DMA write master: splits a command into INCR bursts (no 4 KB crossing), one burst outstanding.
// Latency: cmd accept -> AW after 2 cycles; W beats pass through combinationally; done 1 cycle after last B.
// Backpressure: producer is throttled directly by wready; cmd_ready only in IDLE. Macro AXI_DMA_WR_TAIL_STRB_EN enables tail-beat strobes.
module axi_dma_wr
    import axi_types_pkg::*;
#(
    parameter int AXI_DATA_W    = 128,
    parameter int AXI_ADDR_W    = 32,
    parameter int MAX_BURST_LEN = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [AXI_ADDR_W-1:0]   cmd_addr,
    input  logic [23:0]             cmd_len,
    input  logic [3:0]              cmd_tag,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [AXI_DATA_W-1:0]   in_data,
    output logic [AXI_ID_W-1:0]     m_axi_awid,
    output logic [AXI_ADDR_W-1:0]   m_axi_awaddr,
    output logic [7:0]              m_axi_awlen,
    output logic [2:0]              m_axi_awsize,
    output logic [1:0]              m_axi_awburst,
    output logic                    m_axi_awvalid,
    input  logic                    m_axi_awready,
    output logic [AXI_DATA_W-1:0]   m_axi_wdata,
    output logic [AXI_DATA_W/8-1:0] m_axi_wstrb,
    output logic                    m_axi_wlast,
    output logic                    m_axi_wvalid,
    input  logic                    m_axi_wready,
    input  logic [AXI_ID_W-1:0]     m_axi_bid,
    input  logic [1:0]              m_axi_bresp,
    input  logic                    m_axi_bvalid,
    output logic                    m_axi_bready,
    output logic                    busy,
    output logic                    done,
    output logic                    error
);

    localparam int          BPB        = AXI_DATA_W / 8;
    localparam int          BEAT_SHIFT = $clog2(BPB);
    localparam logic [23:0] BPB_LEN    = 24'(BPB);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CALC,
        S_SEND_AW,
        S_SEND_W,
        S_WAIT_B,
        S_DONE
    } state_t;

    state_t                state, state_nxt;
    logic [AXI_ADDR_W-1:0] cur_addr;
    logic [23:0]           bytes_rem;
    logic [3:0]            tag_r;
    logic [7:0]            burst_len;
    logic [7:0]            beat_cnt;
    logic [7:0]            calc_len;
    logic                  w_hs;
    logic                  unused_bid;

    assign unused_bid = ^m_axi_bid;

    axi_burst_calc #(
        .BEAT_SHIFT    (BEAT_SHIFT),
        .MAX_BURST_LEN (MAX_BURST_LEN)
    ) u_burst_calc (
        .addr_4k   (cur_addr[11:0]),
        .rem       (bytes_rem),
        .burst_len (calc_len)
    );

    assign m_axi_awid    = AXI_ID_W'(tag_r);
    assign m_axi_awaddr  = cur_addr;
    assign m_axi_awlen   = burst_len;
    assign m_axi_awsize  = axi_size_from_bytes(BPB);
    assign m_axi_awburst = AXI_BURST_INCR;
    assign m_axi_wdata   = in_data;
    assign m_axi_wlast   = (beat_cnt == burst_len);
    assign w_hs          = (state == S_SEND_W) && in_valid && m_axi_wready;
    assign done          = (state == S_DONE);
    assign busy          = (state != S_IDLE) && (state != S_DONE);

`ifdef AXI_DMA_WR_TAIL_STRB_EN
    // Final short beat writes only the low bytes still owed; every other beat is full.
    always_comb begin
        m_axi_wstrb = '1;
        if (bytes_rem < BPB_LEN)
            m_axi_wstrb = ~({BPB{1'b1}} << bytes_rem[BEAT_SHIFT-1:0]);
    end
`else
    assign m_axi_wstrb = '1;
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Next-state and handshake outputs; the W channel is a straight wire to the producer in SEND_W.
    always_comb begin
        state_nxt     = state;
        cmd_ready     = 1'b0;
        m_axi_awvalid = 1'b0;
        m_axi_wvalid  = 1'b0;
        in_ready      = 1'b0;
        m_axi_bready  = 1'b0;
        case (state)
            S_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) state_nxt = S_CALC;
            end
            S_CALC: begin
                state_nxt = (bytes_rem == '0) ? S_DONE : S_SEND_AW;
            end
            S_SEND_AW: begin
                m_axi_awvalid = 1'b1;
                if (m_axi_awready) state_nxt = S_SEND_W;
            end
            S_SEND_W: begin
                m_axi_wvalid = in_valid;
                in_ready     = m_axi_wready;
                if (w_hs && m_axi_wlast) state_nxt = S_WAIT_B;
            end
            S_WAIT_B: begin
                m_axi_bready = 1'b1;
                if (m_axi_bvalid) state_nxt = (bytes_rem != '0) ? S_CALC : S_DONE;
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Transfer bookkeeping: command latch, per-burst sizing, per-beat advance, sticky error.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_addr  <= '0;
            bytes_rem <= '0;
            tag_r     <= '0;
            burst_len <= '0;
            beat_cnt  <= '0;
            error     <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        cur_addr  <= {cmd_addr[AXI_ADDR_W-1:BEAT_SHIFT], {BEAT_SHIFT{1'b0}}};
                        bytes_rem <= cmd_len;
                        tag_r     <= cmd_tag;
                        error     <= 1'b0;
                    end
                end
                S_CALC: begin
                    if (bytes_rem != '0) begin
                        burst_len <= calc_len;
                        beat_cnt  <= '0;
                    end
                end
                S_SEND_W: begin
                    if (w_hs) begin
                        beat_cnt  <= beat_cnt + 8'd1;
                        cur_addr  <= cur_addr + AXI_ADDR_W'(BPB);
                        bytes_rem <= (bytes_rem >= BPB_LEN) ? (bytes_rem - BPB_LEN) : '0;
                    end
                end
                S_WAIT_B: begin
                    if (m_axi_bvalid && (m_axi_bresp != AXI_RESP_OKAY)) error <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule
